// File: rtl/hci_prio_stall_arbiter_if.sv
// ---------------------------------------------------------------------------
// hci_prio_stall_arbiter_if
//   One HCI/TCDM-style channel: request/grant handshake with an address,
//   write-enable, write data and byte-enable payload, plus the in-order
//   response path (r_valid / r_data).
//
//   master modport : the initiator (drives req + payload, sees gnt + response)
//   slave  modport : the target    (sees req + payload, drives gnt + response)
//
//   Signals: req, gnt, add[AW], wen (1=read, 0=write), data[DW], be[DW/BW],
//            r_data[DW], r_valid
// ---------------------------------------------------------------------------
interface hci_prio_stall_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int BW = 8
);
  logic             req;
  logic             gnt;
  logic [AW-1:0]    add;
  logic             wen;
  logic [DW-1:0]    data;
  logic [DW/BW-1:0] be;
  logic [DW-1:0]    r_data;
  logic             r_valid;

  modport master (
    output req, add, wen, data, be,
    input  gnt, r_data, r_valid
  );

  modport slave (
    input  req, add, wen, data, be,
    output gnt, r_data, r_valid
  );
endinterface

// File: rtl/hci_prio_stall_arbiter.sv
// ---------------------------------------------------------------------------
// hci_prio_stall_arbiter
//   Shares one HCI memory port between a high-priority master (hi) and a
//   low-priority master (lo). Arbitration is fixed-priority with an
//   anti-starvation stall limit, or round-robin, chosen at runtime by ctrl_i.
//   An in-order owner FIFO remembers who was granted so that each memory
//   response is routed back to the master that issued it.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   ctrl_i  : {arb_policy[1:0], invert_prio, low_prio_max_stall[7:0]}
//             arb_policy 1 = round-robin, anything else = fixed priority
//   hi, lo  : requesting channels (slave side of the interface)
//   mem     : shared memory channel (master side of the interface)
//   err_o   : sticky, a response arrived while nothing was outstanding
// ---------------------------------------------------------------------------
module hci_prio_stall_arbiter #(
  parameter int DW              = 32,
  parameter int AW              = 32,
  parameter int BW              = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [10:0]                     ctrl_i,
  hci_prio_stall_arbiter_if.slave         hi,
  hci_prio_stall_arbiter_if.slave         lo,
  hci_prio_stall_arbiter_if.master        mem,
  output logic                            err_o
);

  typedef struct packed {
    logic [1:0] arb_policy;
    logic       invert_prio;
    logic [7:0] low_prio_max_stall;
  } ctrl_t;

  typedef enum logic {
    OWNER_HI = 1'b0,
    OWNER_LO = 1'b1
  } owner_e;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  ctrl_t ctrl;
  assign ctrl = ctrl_t'(ctrl_i);

  // Registered state
  logic [1:0]       policy_q;
  logic             invert_q;
  logic [7:0]       stall_cnt;
  logic             rr_next_lo;     // 0: hi is next in round-robin, 1: lo
  owner_e           fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic [DW-1:0]    hi_r_data_q;
  logic [DW-1:0]    lo_r_data_q;

  // Combinational decisions
  logic             fifo_full;
  logic             fifo_empty;
  logic             force_s;
  logic             p_is_lo;
  logic             win_lo;
  logic             handshake;
  logic             push;
  logic             pop;
  owner_e           head;
  logic             s_req;
  logic             p_gnt;
  logic             s_gnt;
  logic             cfg_change;
  logic [AW-1:0]    sel_add;
  logic [DW-1:0]    sel_data;
  logic [DW/BW-1:0] sel_be;
  logic             sel_wen;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign fifo_full  = (fifo_cnt == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (fifo_cnt == '0);

  // Primary side is lo when priority is inverted; S is always the other one.
  assign p_is_lo = ctrl.invert_prio;

  // A zero limit disables forcing; otherwise S is forced once it has been
  // passed over exactly low_prio_max_stall times.
  assign force_s = (ctrl.low_prio_max_stall != 8'd0) &&
                   (stall_cnt == ctrl.low_prio_max_stall);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    win_lo = 1'b0;
    if (hi.req && lo.req) begin
      if (ctrl.arb_policy == 2'd1) win_lo = rr_next_lo;
      else                         win_lo = force_s ? !p_is_lo : p_is_lo;
    end else begin
      win_lo = lo.req;
    end
  end

  // Request path is purely combinational: zero added latency.
  assign mem.req  = (hi.req | lo.req) & !fifo_full;
  assign sel_add  = win_lo ? lo.add  : hi.add;
  assign sel_wen  = win_lo ? lo.wen  : hi.wen;
  assign sel_data = win_lo ? lo.data : hi.data;
  assign sel_be   = win_lo ? lo.be   : hi.be;
  assign mem.add  = sel_add;
  assign mem.wen  = sel_wen;
  assign mem.data = sel_data;
  assign mem.be   = sel_be;

  assign handshake = mem.req & mem.gnt;
  assign hi.gnt    = handshake & !win_lo;
  assign lo.gnt    = handshake &  win_lo;

  assign s_req = p_is_lo ? hi.req : lo.req;
  assign p_gnt = p_is_lo ? lo.gnt : hi.gnt;
  assign s_gnt = p_is_lo ? hi.gnt : lo.gnt;

  assign cfg_change = (ctrl.arb_policy != policy_q) | (ctrl.invert_prio != invert_q);

  // A full FIFO already gates mem.req, so push never overflows; a pop in the
  // same cycle does not reopen the slot early.
  assign push = handshake;
  assign pop  = mem.r_valid & !fifo_empty;
  assign head = fifo_mem[rd_ptr];

  // Response routing from the FIFO head; the non-owner holds its last data.
  assign hi.r_valid = pop & (head == OWNER_HI);
  assign lo.r_valid = pop & (head == OWNER_LO);
  assign hi.r_data  = hi.r_valid ? mem.r_data : hi_r_data_q;
  assign lo.r_data  = lo.r_valid ? mem.r_data : lo_r_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      policy_q    <= '0;
      invert_q    <= 1'b0;
      stall_cnt   <= '0;
      rr_next_lo  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      hi_r_data_q <= '0;
      lo_r_data_q <= '0;
      err_o       <= 1'b0;
    end else begin
      policy_q <= ctrl.arb_policy;
      invert_q <= ctrl.invert_prio;

      if (cfg_change || s_gnt)                        stall_cnt <= '0;
      else if (s_req && p_gnt && stall_cnt != 8'hFF)  stall_cnt <= stall_cnt + 8'd1;

      if (handshake) rr_next_lo <= !win_lo;

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (hi.r_valid) hi_r_data_q <= mem.r_data;
      if (lo.r_valid) lo_r_data_q <= mem.r_data;

      if (mem.r_valid && fifo_empty) err_o <= 1'b1;
    end
  end

  // NOTE: the owner storage has no reset; fifo_cnt and the pointers are
  // reset, so an entry is never read before it has been written.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= win_lo ? OWNER_LO : OWNER_HI;
  end

endmodule

// File: tb/tb_hci_prio_stall_arbiter.sv
module tb_hci_prio_stall_arbiter;

  localparam logic [31:0] HI_ADD = 32'h0000_0200;
  localparam logic [31:0] LO_ADD = 32'h0000_0100;

  typedef struct {
    logic        is_lo;
    logic [31:0] add;
    logic        wen;
  } gnt_exp_t;

  typedef struct {
    logic        is_lo;
    logic [31:0] data;
  } rsp_exp_t;

  logic        clk;
  logic        rst_n;
  logic [10:0] ctrl;
  logic        err;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic        auto_resp = 1'b0;
  logic [31:0] resp_word = 32'h0;

  hci_prio_stall_arbiter_if hi_if ();
  hci_prio_stall_arbiter_if lo_if ();
  hci_prio_stall_arbiter_if mem_if ();

  hci_prio_stall_arbiter #(
    .DW(32), .AW(32), .BW(8), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .ctrl_i (ctrl),
    .hi     (hi_if),
    .lo     (lo_if),
    .mem    (mem_if),
    .err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input logic is_lo);
    gnt_exp_t e;
    e.is_lo = is_lo;
    e.add   = is_lo ? LO_ADD : HI_ADD;
    e.wen   = is_lo ? 1'b1 : 1'b0;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic is_lo, input logic [31:0] data);
    rsp_exp_t e;
    e.is_lo = is_lo;
    e.data  = data;
    rq.push_back(e);
  endtask

  // Push a grant pattern ('h'/'l' characters); each grant gets a response
  // carrying resp_word when auto_resp is on.
  task automatic push_pattern(input string pat, input logic [31:0] data, input logic with_rsp);
    for (int i = 0; i < pat.len(); i++) begin
      push_g(pat[i] == "l");
      if (with_rsp) push_r(pat[i] == "l", data);
    end
  endtask

  task automatic run_both(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      hi_if.req = 1'b1;
      lo_if.req = 1'b1;
    end
    tick();
    hi_if.req = 1'b0;
    lo_if.req = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_ctrl(input logic [1:0] pol, input logic inv, input logic [7:0] max);
    tick();
    ctrl = {pol, inv, max};
    tick();
  endtask

  task automatic check_drained(input string name);
    check({name, "_gq_empty"}, 64'(gq.size()), 64'd0);
    check({name, "_rq_empty"}, 64'(rq.size()), 64'd0);
  endtask

  // Memory model: one-cycle read/write latency when auto_resp is enabled.
  initial begin : responder
    logic pend;
    forever begin
      @(negedge clk);
      pend = auto_resp && rst_n && mem_if.req && mem_if.gnt;
      @(posedge clk);
      #1;
      if (auto_resp) begin
        mem_if.r_valid = pend;
        mem_if.r_data  = pend ? resp_word : 32'h0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents a grant or a
  // response, and compares against the expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hi_if.gnt || lo_if.gnt) begin
        check("gnt_exclusive", {63'd0, hi_if.gnt & lo_if.gnt}, 64'd0);
        if (gq.size() == 0) begin
          check("gnt_unexpected", {62'd0, hi_if.gnt, lo_if.gnt}, 64'd0);
        end else begin
          gnt_exp_t e;
          e = gq.pop_front();
          check("gnt_owner", {63'd0, lo_if.gnt}, {63'd0, e.is_lo});
          check("gnt_add",   {32'd0, mem_if.add}, {32'd0, e.add});
          check("gnt_wen",   {63'd0, mem_if.wen}, {63'd0, e.wen});
        end
      end
      if (hi_if.r_valid || lo_if.r_valid) begin
        check("rsp_exclusive", {63'd0, hi_if.r_valid & lo_if.r_valid}, 64'd0);
        if (rq.size() == 0) begin
          check("rsp_unexpected", {62'd0, hi_if.r_valid, lo_if.r_valid}, 64'd0);
        end else begin
          rsp_exp_t e;
          e = rq.pop_front();
          check("rsp_owner", {63'd0, lo_if.r_valid}, {63'd0, e.is_lo});
          check("rsp_data", {32'd0, (lo_if.r_valid ? lo_if.r_data : hi_if.r_data)},
                {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    ctrl           = '0;
    hi_if.req      = 1'b0;
    hi_if.add      = HI_ADD;
    hi_if.wen      = 1'b0;
    hi_if.data     = 32'h5555_AAAA;
    hi_if.be       = 4'hF;
    lo_if.req      = 1'b0;
    lo_if.add      = LO_ADD;
    lo_if.wen      = 1'b1;
    lo_if.data     = 32'h0;
    lo_if.be       = 4'hF;
    mem_if.gnt     = 1'b1;
    mem_if.r_valid = 1'b0;
    mem_if.r_data  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_hi_gnt",     {63'd0, hi_if.gnt},     64'd0);
    check("rst_lo_gnt",     {63'd0, lo_if.gnt},     64'd0);
    check("rst_hi_rvalid",  {63'd0, hi_if.r_valid}, 64'd0);
    check("rst_lo_rvalid",  {63'd0, lo_if.r_valid}, 64'd0);
    check("rst_mem_req",    {63'd0, mem_if.req},    64'd0);
    check("rst_err",        {63'd0, err},           64'd0);
    check("rst_hi_rdata",   {32'd0, hi_if.r_data},  64'd0);
    check("rst_lo_rdata",   {32'd0, lo_if.r_data},  64'd0);
    tick();
    rst_n = 1'b1;

    // Lone lo read, latency 1
    auto_resp = 1'b1;
    resp_word = 32'hDEAD_BEEF;
    push_g(1'b1);
    push_r(1'b1, 32'hDEAD_BEEF);
    tick();
    lo_if.req = 1'b1;
    @(negedge clk);
    check("p1_lo_gnt_same_cycle", {63'd0, lo_if.gnt}, 64'd1);
    tick();
    lo_if.req = 1'b0;
    @(negedge clk);
    check("p1_lo_rvalid_next", {63'd0, lo_if.r_valid}, 64'd1);
    tick();
    @(negedge clk);
    check("p1_lo_rdata_held", {32'd0, lo_if.r_data}, {32'd0, 32'hDEAD_BEEF});
    check("p1_hi_rdata_zero", {32'd0, hi_if.r_data}, 64'd0);
    check_drained("p1");

    // Fixed priority (policy 2), stall limit 3
    set_ctrl(2'd2, 1'b0, 8'd3);
    resp_word = 32'h1111_2222;
    push_pattern("hhhlhhhl", 32'h1111_2222, 1'b1);
    run_both(8);
    check_drained("p2");

    // Inverted priority, no limit: lo always wins
    set_ctrl(2'd0, 1'b1, 8'd0);
    resp_word = 32'h3333_0001;
    push_pattern("llll", 32'h3333_0001, 1'b1);
    run_both(4);
    check_drained("p3a");

    // Normal priority, no limit: hi always wins
    set_ctrl(2'd0, 1'b0, 8'd0);
    resp_word = 32'h3333_0002;
    push_pattern("hhhh", 32'h3333_0002, 1'b1);
    run_both(4);
    check_drained("p3b");

    // Inverted with limit 3: hi stalls twice, then toggling invert clears it
    set_ctrl(2'd0, 1'b1, 8'd3);
    resp_word = 32'h3333_0003;
    push_pattern("ll", 32'h3333_0003, 1'b1);
    run_both(2);
    set_ctrl(2'd0, 1'b0, 8'd3);
    push_pattern("hhhl", 32'h3333_0003, 1'b1);
    run_both(4);
    check_drained("p3c");

    // Round-robin, with a two-cycle memory stall in the middle
    set_ctrl(2'd1, 1'b0, 8'd0);
    resp_word = 32'h4444_0000;
    push_pattern("hlhlhl", 32'h4444_0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      hi_if.req = 1'b1;
      lo_if.req = 1'b1;
    end
    tick();
    mem_if.gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("p4_stall_mem_req", {63'd0, mem_if.req}, 64'd1);
      check("p4_stall_no_gnt",  {62'd0, hi_if.gnt, lo_if.gnt}, 64'd0);
      check("p4_stall_ptr_hi",  {32'd0, mem_if.add}, {32'd0, HI_ADD});
      if (i == 0) tick();
    end
    tick();
    mem_if.gnt = 1'b1;
    tick();
    tick();
    hi_if.req = 1'b0;
    lo_if.req = 1'b0;
    tick();
    tick();
    check_drained("p4");

    // Owner FIFO full: memory withholds responses
    set_ctrl(2'd0, 1'b0, 8'd0);
    auto_resp      = 1'b0;
    mem_if.r_valid = 1'b0;
    push_g(1'b1);
    push_g(1'b0);
    push_g(1'b1);
    push_r(1'b1, 32'hCAFE_0001);
    push_r(1'b0, 32'hCAFE_0002);
    push_r(1'b1, 32'hCAFE_0003);
    tick(); lo_if.req = 1'b1;                                   // grant lo
    tick(); lo_if.req = 1'b0; hi_if.req = 1'b1;                 // grant hi
    tick();                                                     // full
    @(negedge clk);
    check("p5_full_blocks_req", {63'd0, mem_if.req}, 64'd0);
    check("p5_full_no_hi_gnt",  {63'd0, hi_if.gnt},  64'd0);
    tick(); mem_if.r_valid = 1'b1; mem_if.r_data = 32'hCAFE_0001;
    @(negedge clk);
    check("p5_full_pop_no_bypass", {63'd0, mem_if.req}, 64'd0);
    tick(); mem_if.r_valid = 1'b0; hi_if.req = 1'b0; lo_if.req = 1'b1;
    @(negedge clk);
    check("p5_req_after_pop", {63'd0, mem_if.req}, 64'd1);
    tick(); lo_if.req = 1'b0; mem_if.r_valid = 1'b1; mem_if.r_data = 32'hCAFE_0002;
    @(negedge clk);
    check("p5_lo_rdata_held", {32'd0, lo_if.r_data}, {32'd0, 32'hCAFE_0001});
    tick(); mem_if.r_data = 32'hCAFE_0003;
    @(negedge clk);
    check("p5_hi_rdata_held", {32'd0, hi_if.r_data}, {32'd0, 32'hCAFE_0002});
    tick(); mem_if.r_valid = 1'b0;
    tick();
    check_drained("p5");
    check("p5_no_err", {63'd0, err}, 64'd0);

    // Reset with a transaction outstanding, then an orphan response
    push_g(1'b1);
    tick(); lo_if.req = 1'b1;
    tick(); lo_if.req = 1'b0; rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("p6_rst_mem_req", {63'd0, mem_if.req}, 64'd0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("p6_err_clear", {63'd0, err}, 64'd0);
    tick(); mem_if.r_valid = 1'b1; mem_if.r_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check("p6_orphan_hi_rvalid", {63'd0, hi_if.r_valid}, 64'd0);
    check("p6_orphan_lo_rvalid", {63'd0, lo_if.r_valid}, 64'd0);
    tick(); mem_if.r_valid = 1'b0;
    @(negedge clk);
    check("p6_err_set", {63'd0, err}, 64'd1);
    tick(); tick();
    @(negedge clk);
    check("p6_err_sticky", {63'd0, err}, 64'd1);
    check("p6_lo_rdata_reset", {32'd0, lo_if.r_data}, 64'd0);
    check_drained("p6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
